dds_voice_osc: RTL

DDS_VOICE_OSC -- requirements
Module: dds_voice_osc

---
 rtl/dds_voice_osc.sv | 115 +++++++++++
 1 files changed

// File: rtl/dds_voice_osc.sv
// Single-voice DDS oscillator: a 32-bit phase accumulator with portamento, and
// saw/square/triangle/noise waveshaping. One sample is emitted per SAMPLE_EN.
module dds_voice_osc (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SAMPLE_EN,
  input  logic [31:0] ADDER,
  input  logic        GATE,
  input  logic [1:0]  WAVE,
  input  logic [3:0]  GLIDE,
  output logic [11:0] OUT,
  output logic        OUT_VALID,
  output logic        PHASE_WRAP
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic         gate_q;
  logic [31:0]  acc_q, acc_d;
  logic [31:0]  cur_q, cur_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic         played_q, played_d;
  logic         pend_q, pend_run_q, pend_wrap_q;
  logic [11:0]  out_q;
  logic         valid_q, wrap_q;

  logic         rise, stay_run, wrap_d, fb;
  logic [32:0]  sum;
  logic [31:0]  diff;
  logic signed [31:0] shifted, step;
  logic [11:0]  p, wave_val;

  always_comb begin
    rise     = GATE & ~gate_q;
    stay_run = (state_q == RUN) & GATE;
    sum      = {1'b0, acc_q} + {1'b0, cur_q};
    diff     = ADDER - cur_q;
    shifted  = $signed(diff) >>> GLIDE;
    step     = shifted;
    // A shift that rounds the step to zero would stall short of the target.
    if (shifted == '0 && diff != '0)
      step = diff[31] ? '1 : 32'sd1;
    fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    acc_d    = acc_q;
    cur_d    = cur_q;
    lfsr_d   = lfsr_q;
    played_d = played_q;
    wrap_d   = 1'b0;
    if (rise) begin
      acc_d    = '0;
      played_d = 1'b1;
      if (GLIDE == 4'd0 || !played_q)
        cur_d = ADDER;
    end else if (!stay_run) begin
      acc_d = '0;
    end else if (SAMPLE_EN) begin
      acc_d  = sum[31:0];
      wrap_d = sum[32];
      cur_d  = (GLIDE == 4'd0) ? ADDER : cur_q + step;
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  // Shaping reads the accumulator one edge after it was updated.
  always_comb begin
    p = acc_q[31:20];
    case (WAVE)
      2'b00:   wave_val = p;
      2'b01:   wave_val = p[11] ? 12'hFFF : 12'h000;
      2'b10:   wave_val = p[11] ? ~{p[10:0], 1'b0} : {p[10:0], 1'b0};
      default: wave_val = lfsr_q[15:4];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      gate_q      <= 1'b0;
      acc_q       <= '0;
      cur_q       <= '0;
      lfsr_q      <= 16'hACE1;
      played_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_run_q  <= 1'b0;
      pend_wrap_q <= 1'b0;
      out_q       <= 12'h800;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      gate_q   <= GATE;
      acc_q    <= acc_d;
      cur_q    <= cur_d;
      lfsr_q   <= lfsr_d;
      played_q <= played_d;
      case (state_q)
        IDLE:    if (rise)  state_q <= RUN;
        default: if (!GATE) state_q <= IDLE;
      endcase
      pend_q      <= SAMPLE_EN;
      pend_run_q  <= rise | stay_run;
      pend_wrap_q <= wrap_d;
      valid_q     <= pend_q;
      wrap_q      <= pend_q & pend_run_q & pend_wrap_q;
      if (pend_q)
        out_q <= pend_run_q ? wave_val : 12'h800;
    end
  end

  assign OUT        = out_q;
  assign OUT_VALID  = valid_q;
  assign PHASE_WRAP = wrap_q;

endmodule
